vga_pixel_prefetch: RTL and testbench

- Read-side stage between the frame-buffer memory controller's VGA port and the VGA timing/colour stage.
- Walks the frame buffer linearly and issues word reads on the controller's VGA address port.
- Captures the returned words after a fixed read latency and queues their 8-bit colour in a small show-ahead FIFO.
- The VGA stage pops one pixel per active-pixel clock, so memory latency is hidden. Underflow is detected and flagged.

---
 rtl/vga_pixel_prefetch.sv | 127 ++++++++++++
 tb/tb_vga_pixel_prefetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_prefetch.sv
// vga_pixel_prefetch
//   Read-side prefetcher between the frame-buffer controller's VGA read port
//   and the VGA timing/colour stage. Walks the frame linearly, keeps the
//   FIFO topped up while reads are in flight, and presents the head pixel
//   show-ahead so the VGA stage never waits on memory latency.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   frame_start_i  one-cycle pulse at vertical blank: flush and restart frame
//   pix_req_i      VGA stage consumes the head pixel this cycle
//   mem_addr_o     frame-buffer word address presented to the controller
//   mem_data_i     read data, valid RD_LAT cycles after its address; colour in [7:0]
//   pix_data_o     head colour, 8'h00 when empty
//   pix_valid_o    FIFO not empty
//   underflow_o    sticky: pix_req_i seen while empty (cleared by reset only)
//   frame_done_o   every read of the current frame has been issued
//   fifo_level_o   current FIFO occupancy
//
// state | meaning
// IDLE  | out of reset, waiting for the first frame_start
// FETCH | issuing reads for the current frame
// DONE  | last address issued, waiting for frame_start
module vga_pixel_prefetch #(
  parameter int ADDR_W    = 16,
  parameter int FB_WORDS  = 19200,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_start_i,
  input  logic                     pix_req_i,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [15:0]              mem_data_i,
  output logic [7:0]               pix_data_o,
  output logic                     pix_valid_o,
  output logic                     underflow_o,
  output logic                     frame_done_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FB_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [7:0]          fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, inflight;
  logic                underflow_q, frame_done_q;
  logic                issue, capture, push, pop;
  logic                unused_hi;

  assign unused_hi = ^mem_data_i[15:8];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + LVL_W'(vld_q[i]);
  end

  // Counting in-flight reads against free space is what makes overflow impossible.
  assign issue   = (state_q == FETCH) && ((int'(level_q) + int'(inflight)) < DEPTH);
  assign capture = vld_q[RD_LAT-1];
  assign push    = capture && !frame_start_i;
  assign pop     = pix_req_i && pix_valid_o && !frame_start_i;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_data_i[7:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      addr_q       <= FIRST_ADDR;
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (frame_start_i) begin
      // Restart wins over pop, underflow and capture; in-flight returns are dropped.
      state_q      <= FETCH;
      addr_q       <= FIRST_ADDR;
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      if (pix_req_i && !pix_valid_o) underflow_q <= 1'b1;
      if (issue) begin
        // Address holds on the last word so DONE keeps presenting it.
        if (addr_q == LAST_ADDR) begin
          state_q      <= DONE;
          frame_done_q <= 1'b1;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

  assign mem_addr_o   = addr_q;
  assign pix_valid_o  = (level_q != '0);
  assign pix_data_o   = pix_valid_o ? fifo_mem[rd_ptr_q] : 8'h00;
  assign underflow_o  = underflow_q;
  assign frame_done_o = frame_done_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Bench for vga_pixel_prefetch: one instance at RD_LAT=1 (main scoreboard)
// and one at RD_LAT=2 (flush of in-flight reads), sharing stimulus.
module tb_vga_pixel_prefetch;

  localparam int FBW = 19200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_req = 1'b0;

  logic [15:0] addr1, data1, addr2, data2;
  logic [7:0]  pd1, pd2;
  logic        pv1, pv2, uf1, uf2, fd1, fd2;
  logic [4:0]  lvl1, lvl2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  vga_pixel_prefetch #(.ADDR_W(16), .FB_WORDS(FBW), .BASE_ADDR(0), .DEPTH(16), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start), .pix_req_i(pix_req),
    .mem_addr_o(addr1), .mem_data_i(data1), .pix_data_o(pd1), .pix_valid_o(pv1),
    .underflow_o(uf1), .frame_done_o(fd1), .fifo_level_o(lvl1));

  vga_pixel_prefetch #(.ADDR_W(16), .FB_WORDS(FBW), .BASE_ADDR(0), .DEPTH(16), .RD_LAT(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start), .pix_req_i(pix_req),
    .mem_addr_o(addr2), .mem_data_i(data2), .pix_data_o(pd2), .pix_valid_o(pv2),
    .underflow_o(uf2), .frame_done_o(fd2), .fifo_level_o(lvl2));

  // Memory models: data = address, delayed by the read latency.
  logic [15:0] pipe1;
  logic [15:0] pipe2 [2];
  always @(posedge clk) begin
    pipe1    <= addr1;
    pipe2[0] <= addr2;
    pipe2[1] <= pipe2[0];
  end
  assign data1 = pipe1;
  assign data2 = pipe2[1];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    exp_q.delete();
    for (int i = 0; i < FBW; i++) exp_q.push_back(8'(i));
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    load_frame();
    cyc();
    frame_start = 1'b0;
  endtask

  // Scoreboard: every pop of the RD_LAT=1 instance must return the next frame pixel.
  always @(negedge clk) begin
    if (!reset && !frame_start && pix_req && pv1) begin
      if (exp_q.size() == 0) check_val("sb_empty", 1, 0);
      else check_val("pix_data", {24'd0, pd1}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    repeat (3) cyc();
    check_val("rst_addr", addr1, 0);
    check_val("rst_valid", pv1, 0);
    check_val("rst_data", pd1, 0);
    check_val("rst_uf", uf1, 0);
    check_val("rst_done", fd1, 0);
    check_val("rst_level", lvl1, 0);

    reset = 1'b0;
    repeat (3) cyc();
    check_val("idle_addr", addr1, 0);
    check_val("idle_level", lvl1, 0);

    // Fill with pix_req idle.
    start_frame();
    check_val("fs_valid0", pv1, 0);
    cyc();
    check_val("fs_valid1", pv1, 0);
    cyc();
    check_val("fs_valid2", pv1, 1);
    check_val("fs_data", pd1, 8'h00);
    check_val("fs_valid2_lat2", pv2, 0);
    cyc();
    check_val("fs_valid3_lat2", pv2, 1);
    repeat (20) cyc();
    check_val("fill_addr", addr1, 16);
    check_val("fill_level", lvl1, 16);
    check_val("fill_addr_lat2", addr2, 16);
    check_val("fill_level_lat2", lvl2, 16);

    // Streaming: scoreboard checks the wrapping byte sequence.
    pix_req = 1'b1;
    repeat (300) cyc();
    check_val("stream_uf", uf1, 0);
    check_val("stream_valid", pv1, 1);

    hit = 1'b0;
    for (int i = 0; i < 25000 && !hit; i++) begin
      cyc();
      if (fd1) hit = 1'b1;
    end
    check_val("frame_done_seen", hit, 1);
    check_val("done_addr", addr1, FBW - 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      if (!pv1) hit = 1'b1;
    end
    check_val("drain_seen", hit, 1);
    check_val("drain_level", lvl1, 0);
    check_val("drain_uf", uf1, 0);
    check_val("drain_sb_left", exp_q.size(), 0);
    check_val("done_hold", fd1, 1);
    cyc();
    check_val("end_uf", uf1, 1);
    pix_req = 1'b0;

    // Restart with two reads in flight on the RD_LAT=2 instance.
    start_frame();
    repeat (4) cyc();
    start_frame();
    check_val("flush_level_lat2", lvl2, 0);
    check_val("flush_valid_lat2", pv2, 0);
    check_val("flush_level", lvl1, 0);
    check_val("flush_done", fd1, 0);
    cyc();
    check_val("flush_stale1", lvl2, 0);
    cyc();
    check_val("flush_stale2", lvl2, 0);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc();
      if (pv2) hit = 1'b1;
    end
    check_val("restart_valid_lat2", hit, 1);
    check_val("restart_data_lat2", pd2, 8'h00);

    // Async reset mid-fetch at level 9.
    start_frame();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (lvl1 == 9) hit = 1'b1;
      else cyc();
    end
    check_val("level9_seen", hit, 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_addr", addr1, 0);
    check_val("arst_valid", pv1, 0);
    check_val("arst_data", pd1, 0);
    check_val("arst_uf", uf1, 0);
    check_val("arst_done", fd1, 0);
    check_val("arst_level", lvl1, 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    check_val("post_rst_addr", addr1, 0);
    check_val("post_rst_level", lvl1, 0);

    // Underflow: frame_start has priority, then empty pix_req sets sticky flag.
    frame_start = 1'b1;
    pix_req = 1'b1;
    load_frame();
    cyc();
    frame_start = 1'b0;
    check_val("fs_prio_uf", uf1, 0);
    cyc();
    check_val("uf_set", uf1, 1);
    check_val("uf_set_lat2", uf2, 1);
    check_val("uf_data", pd1, 0);
    pix_req = 1'b0;
    start_frame();
    check_val("uf_sticky1", uf1, 1);
    start_frame();
    check_val("uf_sticky2", uf1, 1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
